// File: rtl/chip8_mem_pkg.sv
// Shared types and defaults for the CHIP-8 memory arbiter.
// Contents:
//   ADDR_W_DEF / DATA_W_DEF / LOCK_MAX_DEF - default bus geometry and lock bound
//   owner_e  - which client owns the current access (OWN_CPU, OWN_GPU)
//   state_e  - arbiter FSM states (IDLE, ACK)
package chip8_mem_pkg;

    localparam int unsigned ADDR_W_DEF   = 12;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned LOCK_MAX_DEF = 16;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_GPU = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, GPU and RAM-side signals around the memory arbiter.
// Modports:
//   slave  - the arbiter: takes client requests and RAM read data, drives acks,
//            client read data and the RAM command
//   master - the environment (CPU, GPU, RAM): the mirror image of slave
interface mem_arbiter_if
    import chip8_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    // CPU port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    // GPU port
    logic              gpu_req;
    logic              gpu_we;
    logic              gpu_lock;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_wdata;
    logic              gpu_ack;
    logic [DATA_W-1:0] gpu_rdata;
    // Single-port synchronous RAM
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  gpu_req, gpu_we, gpu_lock, gpu_addr, gpu_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, gpu_ack, gpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output gpu_req, gpu_we, gpu_lock, gpu_addr, gpu_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, gpu_ack, gpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory arbiter (pure combinational).
// Ports:
//   cpu_req, gpu_req   - pending requests
//   lock_active        - GPU holds ownership: only the GPU may be granted
//   last_winner        - previous grant (only with MEM_ARB_ROUND_ROBIN_EN)
//   grant_cpu/grant_gpu - at most one high
// Build option MEM_ARB_ROUND_ROBIN_EN: conflicts alternate against last_winner;
// without it the CPU always wins a conflict.
module mem_arb_pick
    import chip8_mem_pkg::*;
(
    input  logic   cpu_req,
    input  logic   gpu_req,
    input  logic   lock_active,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_e last_winner,
`endif
    output logic   grant_cpu,
    output logic   grant_gpu
);

    always_comb begin
        grant_cpu = 1'b0;
        grant_gpu = 1'b0;
        if (lock_active) begin
            // CPU waits even when the GPU is momentarily not requesting.
            grant_gpu = gpu_req;
        end else if (cpu_req && gpu_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (last_winner == OWN_CPU) begin
                grant_gpu = 1'b1;
            end else begin
                grant_cpu = 1'b1;
            end
`else
            grant_cpu = 1'b1;
`endif
        end else begin
            grant_cpu = cpu_req;
            grant_gpu = gpu_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/GPU arbiter in front of a single-port synchronous RAM.
// One access per two cycles: IDLE issues the winner's command to the RAM
// combinationally, ACK returns the one-cycle ack with the RAM read data.
// A GPU grant with gpu_lock set keeps the RAM for the GPU until gpu_lock drops
// or LOCK_MAX locked grants have been made, after which a waiting CPU goes first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave (CPU, GPU and RAM signals)
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate winners on unlocked conflicts.
module mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    state_e             state_q;
    owner_e             owner_q;
    logic               locked_q;
    logic [CNT_W-1:0]   lock_cnt_q;
    logic               cpu_ack_q;
    logic               gpu_ack_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e             last_winner_q;
`endif

    logic eval;
    logic lock_active;
    logic grant_cpu;
    logic grant_gpu;

    // rst_n gates evaluation so the RAM sees no command while reset is held.
    assign eval        = (state_q == IDLE) && rst_n;
    assign lock_active = locked_q && bus.gpu_lock && (lock_cnt_q < CNT_W'(LOCK_MAX));

    mem_arb_pick u_pick (
        .cpu_req     (bus.cpu_req),
        .gpu_req     (bus.gpu_req),
        .lock_active (lock_active),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_winner (last_winner_q),
`endif
        .grant_cpu   (grant_cpu),
        .grant_gpu   (grant_gpu)
    );

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (eval && grant_cpu) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (eval && grant_gpu) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.gpu_we;
            bus.mem_addr  = bus.gpu_addr;
            bus.mem_wdata = bus.gpu_wdata;
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.gpu_ack   = gpu_ack_q;
    assign bus.cpu_rdata = (state_q == ACK && owner_q == OWN_CPU) ? bus.mem_rdata : '0;
    assign bus.gpu_rdata = (state_q == ACK && owner_q == OWN_GPU) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_CPU;
            locked_q      <= 1'b0;
            lock_cnt_q    <= '0;
            cpu_ack_q     <= 1'b0;
            gpu_ack_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_winner_q <= OWN_GPU;
`endif
        end else begin
            cpu_ack_q <= 1'b0;
            gpu_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Lock dropped or exhausted: release before this grant.
                    if (locked_q && !lock_active) begin
                        locked_q   <= 1'b0;
                        lock_cnt_q <= '0;
                    end
                    if (grant_cpu) begin
                        state_q    <= ACK;
                        owner_q    <= OWN_CPU;
                        cpu_ack_q  <= 1'b1;
                        locked_q   <= 1'b0;
                        lock_cnt_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_winner_q <= OWN_CPU;
`endif
                    end else if (grant_gpu) begin
                        state_q   <= ACK;
                        owner_q   <= OWN_GPU;
                        gpu_ack_q <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_winner_q <= OWN_GPU;
`endif
                        if (bus.gpu_lock) begin
                            // The grant that takes the lock counts as the first.
                            locked_q   <= 1'b1;
                            lock_cnt_q <= lock_active ? lock_cnt_q + CNT_W'(1) : CNT_W'(1);
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios push the acks they
// expect (cycle, client, read data) onto a scoreboard; a negedge monitor pops
// and compares every ack the arbiter produces.
module tb_mem_arbiter;
    import chip8_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(12), .DATA_W(8), .LOCK_MAX(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: unwritten locations hold a fixed preload pattern.
    logic [7:0] ram    [4096];
    bit         ram_wr [4096];

    function automatic logic [7:0] ram_init(input logic [11:0] a);
        case (a)
            12'h200: return 8'h12;
            12'h201: return 8'h34;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]    <= bus.mem_wdata;
                ram_wr[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr]
                                                      : ram_init(bus.mem_addr);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        bit         gpu;
        logic [7:0] data;
        bit         chk_data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push(input int c, input bit gpu, input logic [7:0] data, input bit chk);
        exp_t e;
        e.cyc      = c;
        e.gpu      = gpu;
        e.data     = data;
        e.chk_data = chk;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus.cpu_ack || bus.gpu_ack) begin
            check_eq("ack_onehot", 32'(bus.cpu_ack & bus.gpu_ack), 0);
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 32'({bus.gpu_ack, bus.cpu_ack}), 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                check_eq("ack_is_gpu", 32'(bus.gpu_ack), 32'(mon_e.gpu));
                if (mon_e.chk_data) begin
                    check_eq("ack_rdata",
                             32'(mon_e.gpu ? bus.gpu_rdata : bus.cpu_rdata), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.gpu_req   = 1'b0;
        bus.gpu_we    = 1'b0;
        bus.gpu_lock  = 1'b0;
        bus.gpu_addr  = '0;
        bus.gpu_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        check_eq("rst_cpu_ack", 32'(bus.cpu_ack), 0);
        check_eq("rst_gpu_ack", 32'(bus.gpu_ack), 0);
        check_eq("rst_mem_en", 32'(bus.mem_en), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_mem_en", 32'(bus.mem_en), 0);
        check_eq("idle_mem_addr", 32'(bus.mem_addr), 0);
        step();
    endtask

    task automatic drain(input string tag);
        repeat (3) step();
        check_eq(tag, 32'(sb.size()), 0);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int c;

        // CPU-only read: command in the request cycle, ack one edge later.
        do_reset();
        c = cyc;
        bus.cpu_addr = 12'h200;
        bus.cpu_req  = 1'b1;
        push(c + 1, 1'b0, 8'h12, 1'b1);
        @(negedge clk);
        check_eq("s1_mem_en", 32'(bus.mem_en), 1);
        check_eq("s1_mem_addr", 32'(bus.mem_addr), 'h200);
        step();
        bus.cpu_req = 1'b0;
        drain("s1_sb_empty");

        // Simultaneous requests held four cycles.
        do_reset();
        c = cyc;
        bus.cpu_addr = 12'h200;
        bus.gpu_addr = 12'h201;
        bus.cpu_req  = 1'b1;
        bus.gpu_req  = 1'b1;
        push(c + 1, 1'b0, 8'h12, 1'b1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(c + 3, 1'b1, 8'h34, 1'b1);
`else
        push(c + 3, 1'b0, 8'h12, 1'b1);
`endif
        step();
        @(negedge clk);
        check_eq("s2_ack_mem_en", 32'(bus.mem_en), 0);
        check_eq("s2_ack_mem_addr", 32'(bus.mem_addr), 0);
        repeat (3) step();
        bus.cpu_req = 1'b0;
        bus.gpu_req = 1'b0;
        drain("s2_sb_empty");

        // Lock: five GPU accesses while the CPU waits, then the CPU.
        do_reset();
        c = cyc;
        bus.gpu_addr = 12'h201;
        bus.gpu_lock = 1'b1;
        bus.gpu_req  = 1'b1;
        for (int k = 0; k < 5; k++) push(c + 1 + 2 * k, 1'b1, 8'h34, 1'b1);
        push(c + 11, 1'b0, 8'h12, 1'b1);
        step();
        bus.cpu_addr = 12'h200;
        bus.cpu_req  = 1'b1;
        step();
        @(negedge clk);
        check_eq("s3_locked_addr", 32'(bus.mem_addr), 'h201);
        repeat (7) step();
        bus.gpu_lock = 1'b0;
        repeat (2) step();
        bus.cpu_req = 1'b0;
        bus.gpu_req = 1'b0;
        drain("s3_sb_empty");

        // Starvation bound: lock held forever, CPU gets in after 16 GPU acks.
        do_reset();
        c = cyc;
        bus.gpu_addr = 12'h201;
        bus.gpu_lock = 1'b1;
        bus.gpu_req  = 1'b1;
        for (int k = 0; k < 16; k++) push(c + 1 + 2 * k, 1'b1, 8'h34, 1'b1);
        push(c + 33, 1'b0, 8'h12, 1'b1);
        push(c + 35, 1'b1, 8'h34, 1'b1);
        step();
        bus.cpu_addr = 12'h200;
        bus.cpu_req  = 1'b1;
        repeat (32) step();
        bus.cpu_req = 1'b0;
        repeat (2) step();
        bus.gpu_req  = 1'b0;
        bus.gpu_lock = 1'b0;
        drain("s4_sb_empty");

        // GPU write followed by a CPU read of the same byte.
        do_reset();
        c = cyc;
        bus.gpu_addr  = 12'h050;
        bus.gpu_wdata = 8'hA5;
        bus.gpu_we    = 1'b1;
        bus.gpu_req   = 1'b1;
        push(c + 1, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        check_eq("s5_mem_we", 32'(bus.mem_we), 1);
        check_eq("s5_mem_wdata", 32'(bus.mem_wdata), 'hA5);
        step();
        bus.gpu_req = 1'b0;
        bus.gpu_we  = 1'b0;
        step();
        bus.cpu_addr = 12'h050;
        bus.cpu_req  = 1'b1;
        push(c + 3, 1'b0, 8'hA5, 1'b1);
        step();
        bus.cpu_req = 1'b0;
        drain("s5_sb_empty");

        // Reset during ACK aborts the access; the held request is re-granted.
        do_reset();
        c = cyc;
        bus.cpu_addr = 12'h200;
        bus.cpu_req  = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check_eq("s6_rst_cpu_ack", 32'(bus.cpu_ack), 0);
        check_eq("s6_rst_mem_en", 32'(bus.mem_en), 0);
        step();
        rst_n = 1'b1;
        push(c + 3, 1'b0, 8'h12, 1'b1);
        step();
        bus.cpu_req = 1'b0;
        drain("s6_sb_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
